// File: rtl/proc_pkg.sv
// Shared constants for the program-memory loader: geometry defaults, NOP word, FSM encoding.
// Pure declarations, no logic.
package proc_pkg;
   localparam int P_DEPTH  = 128;
   localparam int P_ADDR_W = 7;
   localparam int P_DATA_W = 16;

   localparam logic [15:0] NOP_WORD = 16'h0000;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_START = 2'd2;
   localparam state_t ST_RUN   = 2'd3;
endpackage

// File: rtl/prog_ram_128x16.sv
// Simple dual-port program RAM: synchronous write, registered read (1-cycle latency).
// No backpressure; contents and read register are not reset.
module prog_ram_128x16 #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/prog_loader_mem.sv
// Loads a host program into RAM, pulses start, then serves fetches with 1-cycle latency.
// in_ready is high only in LOAD; fetches past word_count return NOP, outputs hold between fetches.
module prog_loader_mem
   import proc_pkg::*;
#(
   parameter int DEPTH  = P_DEPTH,
   parameter int ADDR_W = P_ADDR_W,
   parameter int DATA_W = P_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ram_read_en,
   output logic [DATA_W-1:0] instr_out,
   output logic              start,
   output logic              busy,
   output logic              loaded,
   output logic [ADDR_W:0]   word_count,
   output logic              len_err
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              loaded_q, loaded_d;
   logic              len_err_q, len_err_d;
   logic              start_q, start_d;
   logic              nop_sel_q, nop_sel_d;

   logic              beat_acc;
   logic              last_slot;
   logic              rd_fire;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   assign beat_acc  = in_valid & in_ready;
   assign last_slot = (wr_ptr_q == ADDR_W'(DEPTH - 1));
   assign rd_fire   = (state_q == ST_RUN) & ram_read_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         word_count_q <= '0;
         loaded_q     <= 1'b0;
         len_err_q    <= 1'b0;
         start_q      <= 1'b0;
         nop_sel_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         word_count_q <= word_count_d;
         loaded_q     <= loaded_d;
         len_err_q    <= len_err_d;
         start_q      <= start_d;
         nop_sel_q    <= nop_sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (load_req) state_d = ST_LOAD;
         ST_LOAD:  if (beat_acc && (in_last || last_slot)) state_d = ST_START;
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (load_req) state_d = ST_LOAD;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_LOAD);
      busy     = (state_q == ST_LOAD);
      ram_we   = beat_acc;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      word_count_d = word_count_q;
      loaded_d     = loaded_q;
      len_err_d    = len_err_q;
      nop_sel_d    = nop_sel_q;
      start_d      = (state_d == ST_START);

      if (load_req && (state_q == ST_IDLE || state_q == ST_RUN)) begin
         wr_ptr_d     = '0;
         word_count_d = '0;
         loaded_d     = 1'b0;
         len_err_d    = 1'b0;
      end

      // The pointer parks on the last slot; the load always exits there.
      if (beat_acc) begin
         word_count_d = word_count_q + 1'b1;
         if (!last_slot) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end else if (!in_last) begin
            len_err_d = 1'b1;
         end
      end

      if (state_q == ST_START) begin
         loaded_d = 1'b1;
      end

      if (rd_fire) begin
         nop_sel_d = !({1'b0, pc} < word_count_q);
      end
   end

   prog_ram_128x16 #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .re    (rd_fire),
      .raddr (pc),
      .rdata (ram_rdata)
   );

   // Select flag is captured with the read, so the NOP override holds with the data.
   assign instr_out  = nop_sel_q ? DATA_W'(NOP_WORD) : ram_rdata;
   assign start      = start_q;
   assign loaded     = loaded_q;
   assign word_count = word_count_q;
   assign len_err    = len_err_q;
endmodule

// File: tb/tb_prog_loader_mem.sv
// Directed bench for prog_loader_mem: load, fetch, backpressure, truncation, reload, reset.
module tb_prog_loader_mem;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_req;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        in_ready;
   logic [6:0]  pc;
   logic        ram_read_en;
   logic [15:0] instr_out;
   logic        start;
   logic        busy;
   logic        loaded;
   logic [7:0]  word_count;
   logic        len_err;

   int pass_cnt  = 0;
   int check_cnt = 0;

   prog_loader_mem dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_req    (load_req),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .pc          (pc),
      .ram_read_en (ram_read_en),
      .instr_out   (instr_out),
      .start       (start),
      .busy        (busy),
      .loaded      (loaded),
      .word_count  (word_count),
      .len_err     (len_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_start"}, 32'(start), 32'd0);
      check({tag, "_loaded"}, 32'(loaded), 32'd0);
      check({tag, "_word_count"}, 32'(word_count), 32'd0);
      check({tag, "_len_err"}, 32'(len_err), 32'd0);
      check({tag, "_instr_out"}, 32'(instr_out), 32'd0);
   endtask

   task automatic fetch(input logic [6:0] addr);
      pc = addr;
      ram_read_en = 1'b1;
      step();
      ram_read_en = 1'b0;
   endtask

   initial begin
      logic [15:0] prog4 [4];
      int idx;
      int cyc;
      int start_cnt;

      prog4[0] = 16'h1111; prog4[1] = 16'h2222; prog4[2] = 16'h3333; prog4[3] = 16'h4444;
      rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      pc = '0; ram_read_en = 1'b0;
      step();
      step();
      check_reset_vals("rst");
      rst_n = 1'b1;
      step();

      // Basic 4-word load
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      check("load_busy", 32'(busy), 32'd1);
      check("load_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = prog4[i];
         in_last  = (i == 3);
         step();
         if (i == 2) check("start_early", 32'(start), 32'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("start_pulse", 32'(start), 32'd1);
      check("wc4", 32'(word_count), 32'd4);
      check("ready_after_last", 32'(in_ready), 32'd0);
      step();
      check("start_one_cycle", 32'(start), 32'd0);
      check("loaded", 32'(loaded), 32'd1);

      fetch(7'd2);
      check("fetch_pc2", 32'(instr_out), 32'h3333);
      fetch(7'd5);
      check("fetch_oor", 32'(instr_out), 32'h0000);
      fetch(7'd1);
      check("fetch_pc1", 32'(instr_out), 32'h2222);
      pc = 7'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold", 32'(instr_out), 32'h2222);
      end

      // Backpressure: random valid gaps, 8 words
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      check("bp_loaded_cleared", 32'(loaded), 32'd0);
      check("bp_wc_cleared", 32'(word_count), 32'd0);
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 200) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = in_valid ? (16'hA000 + 16'(idx)) : 16'hDEAD;
         in_last  = (idx == 7);
         step();
         if (in_valid) idx++;
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("bp_done", 32'(idx), 32'd8);
      check("bp_start", 32'(start), 32'd1);
      check("bp_wc", 32'(word_count), 32'd8);
      step();
      for (int i = 0; i < 8; i++) begin
         fetch(7'(i));
         check("bp_fetch", 32'(instr_out), 32'(16'hA000 + 16'(i)));
      end

      // Truncation: 130 beats, no in_last
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      start_cnt = 0;
      for (int i = 0; i < 130; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h5000 + 16'(i);
         in_last  = 1'b0;
         step();
         if (start) start_cnt++;
         if (i == 127) begin
            check("trunc_ready_fall", 32'(in_ready), 32'd0);
            check("trunc_len_err", 32'(len_err), 32'd1);
            check("trunc_wc", 32'(word_count), 32'd128);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (start) start_cnt++;
      end
      check("trunc_start_once", 32'(start_cnt), 32'd1);
      check("trunc_wc_hold", 32'(word_count), 32'd128);
      fetch(7'd127);
      check("trunc_pc127", 32'(instr_out), 32'h507F);
      fetch(7'd0);
      check("trunc_pc0", 32'(instr_out), 32'h5000);

      // Reload with simultaneous fetch
      pc = 7'd1;
      ram_read_en = 1'b1;
      load_req = 1'b1;
      step();
      ram_read_en = 1'b0;
      load_req = 1'b0;
      check("reload_read", 32'(instr_out), 32'h5001);
      check("reload_busy", 32'(busy), 32'd1);
      check("reload_loaded", 32'(loaded), 32'd0);
      check("reload_len_err", 32'(len_err), 32'd0);
      check("reload_wc", 32'(word_count), 32'd0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 16'hBEE0 + 16'(i);
         in_last  = (i == 1);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("reload_start", 32'(start), 32'd1);
      check("reload_hold_instr", 32'(instr_out), 32'h5001);
      step();
      fetch(7'd3);
      check("reload_pc3_nop", 32'(instr_out), 32'h0000);
      fetch(7'd1);
      check("reload_pc1", 32'(instr_out), 32'hBEE1);
      fetch(7'd0);
      check("reload_pc0", 32'(instr_out), 32'hBEE0);

      // Reset in the middle of a 6-beat load
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'hC000 + 16'(i);
         in_last  = 1'b0;
         step();
      end
      check("mid_wc3", 32'(word_count), 32'd3);
      rst_n = 1'b0;
      step();
      check_reset_vals("midrst");
      rst_n = 1'b1;
      start_cnt = 0;
      for (int i = 3; i < 6; i++) begin
         in_data = 16'hC000 + 16'(i);
         in_last = (i == 5);
         step();
         if (start) start_cnt++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
      if (start) start_cnt++;
      check("idle_no_start", 32'(start_cnt), 32'd0);
      check("idle_wc", 32'(word_count), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
